// File: rtl/cnn_pkg.sv
// Shared types and helpers for the streaming conv + max-pool block:
// FSM encoding, accumulator sizing, saturation and the 3x3 tap offset table.
package cnn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_LOAD_I,
        ST_CONV,
        ST_EMIT,
        ST_DONE
    } state_t;

    localparam int         N_TAPS   = 9;
    localparam logic [3:0] LAST_TAP = 4'd8;
    localparam logic [3:0] FIN_STEP = 4'd9;

    localparam int TAP_DR [N_TAPS] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
    localparam int TAP_DC [N_TAPS] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};

    // Four guard bits cover the worst-case sum of nine full-scale products.
    function automatic int acc_width(input int data_w);
        return 2 * data_w + 4;
    endfunction

    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// One filter lane: nine kernel registers, multiply-accumulate over the taps,
// shift and saturate on the finalise cycle, running 2x2 max and optional ReLU.
module conv_mac_lane
    import cnn_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int FRAC    = 0,
    parameter int RELU_EN = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     w_we,
    input  logic [3:0]               w_tap,
    input  logic signed [DATA_W-1:0] w_data,
    input  logic                     acc_clr,
    input  logic                     mac_en,
    input  logic                     fin_en,
    input  logic                     first,
    input  logic [3:0]               tap,
    input  logic signed [DATA_W-1:0] pix,
    output logic signed [DATA_W-1:0] pool_val
);

    localparam int ACC_W = acc_width(DATA_W);

    logic signed [DATA_W-1:0]   kern [N_TAPS];
    logic signed [ACC_W-1:0]    acc;
    logic signed [DATA_W-1:0]   max_q;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    shifted;
    logic signed [63:0]         sat_val;
    logic signed [DATA_W-1:0]   conv_val;
    logic signed [DATA_W-1:0]   max_next;

    always_comb begin
        prod     = (2*DATA_W)'(kern[tap]) * (2*DATA_W)'(pix);
        shifted  = acc >>> FRAC;
        sat_val  = sat(64'(shifted), DATA_W);
        conv_val = sat_val[DATA_W-1:0];
        max_next = (first || (conv_val > max_q)) ? conv_val : max_q;
        pool_val = ((RELU_EN != 0) && max_next[DATA_W-1]) ? '0 : max_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_TAPS; i++) kern[i] <= '0;
            acc   <= '0;
            max_q <= '0;
        end else begin
            if (w_we) kern[w_tap] <= w_data;
            if (acc_clr) begin
                acc <= '0;
            end else if (mac_en) begin
                acc <= acc + ACC_W'(prod);
            end else if (fin_en) begin
                acc   <= '0;
                max_q <= max_next;
            end
        end
    end

endmodule

// File: rtl/conv_pool_stream.sv
// Streaming conv + 2x2 max-pool top: owns the FSM, load/scan counters and the
// unpadded frame buffer; the per-filter arithmetic lives in conv_mac_lane.
module conv_pool_stream
    import cnn_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int IMG     = 14,
    parameter int PAD     = 1,
    parameter int N_FILT  = 2,
    parameter int FRAC    = 0,
    parameter int RELU_EN = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     w_load,
    input  logic                     w_valid,
    input  logic [DATA_W-1:0]        w_in,
    input  logic                     i_load,
    input  logic                     img_valid,
    input  logic [DATA_W-1:0]        img_in,
    output logic [N_FILT*DATA_W-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     done_pooling,
    output logic                     busy,
    output logic                     err
);

    localparam int O     = IMG + 2*PAD - 2;
    localparam int P     = O / 2;
    localparam int PIX_N = IMG * IMG;
    localparam int AW    = (PIX_N > 1) ? $clog2(PIX_N) : 1;
    localparam int PW    = (P > 1) ? $clog2(P) : 1;
    localparam int FW    = (N_FILT > 1) ? $clog2(N_FILT) : 1;

    state_t state, state_next;

    logic signed [DATA_W-1:0] fb [PIX_N];

    logic [FW-1:0]  wf;
    logic [3:0]     wt;
    logic [AW-1:0]  pix_cnt;
    logic [PW-1:0]  pr, pc;
    logic [1:0]     q;
    logic [3:0]     step;
    logic           prime;

    logic           w_last, pix_last, conv_run, conv_fin, pool_last, grid_last;
    logic [3:0]     tap_idx;
    logic [AW-1:0]  fb_addr;
    logic signed [DATA_W-1:0]  pix_rd;
    logic [N_FILT*DATA_W-1:0]  pool_bus;
    int             row_i, col_i;

    assign w_last    = w_valid && (wt == LAST_TAP) && (wf == FW'(N_FILT - 1));
    assign pix_last  = img_valid && (pix_cnt == AW'(PIX_N - 1));
    assign conv_run  = (state == ST_CONV) && !prime;
    assign conv_fin  = conv_run && (step == FIN_STEP);
    assign pool_last = conv_fin && (q == 2'd3);
    assign grid_last = (pr == PW'(P - 1)) && (pc == PW'(P - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (w_load)      state_next = ST_LOAD_W;
                else if (i_load) state_next = ST_LOAD_I;
            end
            ST_LOAD_W: if (w_last)   state_next = ST_IDLE;
            ST_LOAD_I: if (pix_last) state_next = ST_CONV;
            ST_CONV:   if (pool_last) state_next = ST_EMIT;
            ST_EMIT:   if (out_ready) state_next = grid_last ? ST_DONE : ST_CONV;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy         = (state != ST_IDLE);
        out_valid    = (state == ST_EMIT);
        done_pooling = (state == ST_DONE);
    end

    // Conv position (2pr+q[1], 2pc+q[0]) plus tap offset, shifted back into unpadded coordinates.
    always_comb begin
        tap_idx = (step < FIN_STEP) ? step : 4'd0;
        row_i   = 2 * int'(pr) + int'(q[1]) + TAP_DR[tap_idx] - PAD;
        col_i   = 2 * int'(pc) + int'(q[0]) + TAP_DC[tap_idx] - PAD;
        fb_addr = '0;
        pix_rd  = '0;
        if (row_i >= 0 && row_i < IMG && col_i >= 0 && col_i < IMG) begin
            fb_addr = AW'(row_i * IMG + col_i);
            pix_rd  = fb[fb_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_LOAD_I && img_valid) fb[pix_cnt] <= img_in;
    end

    // A one-cycle lead-in after the frame load clears the accumulators before the first tap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wf       <= '0;
            wt       <= '0;
            pix_cnt  <= '0;
            pr       <= '0;
            pc       <= '0;
            q        <= '0;
            step     <= '0;
            prime    <= 1'b0;
            out_data <= '0;
            err      <= 1'b0;
        end else begin
            err   <= (state == ST_IDLE) ? (w_load && i_load) : (w_load || i_load);
            prime <= (state == ST_LOAD_I) && pix_last;
            unique case (state)
                ST_IDLE: begin
                    wf      <= '0;
                    wt      <= '0;
                    pix_cnt <= '0;
                    pr      <= '0;
                    pc      <= '0;
                    q       <= '0;
                    step    <= '0;
                end
                ST_LOAD_W: begin
                    if (w_valid) begin
                        if (wt == LAST_TAP) begin
                            wt <= '0;
                            wf <= wf + FW'(1);
                        end else begin
                            wt <= wt + 4'd1;
                        end
                    end
                end
                ST_LOAD_I: if (img_valid) pix_cnt <= pix_cnt + AW'(1);
                ST_CONV: begin
                    if (conv_fin) begin
                        step <= '0;
                        q    <= q + 2'd1;
                        if (q == 2'd3) out_data <= pool_bus;
                    end else if (conv_run) begin
                        step <= step + 4'd1;
                    end
                end
                ST_EMIT: begin
                    if (out_ready && !grid_last) begin
                        if (pc == PW'(P - 1)) begin
                            pc <= '0;
                            pr <= pr + PW'(1);
                        end else begin
                            pc <= pc + PW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar f = 0; f < N_FILT; f++) begin : g_lane
        conv_mac_lane #(
            .DATA_W  (DATA_W),
            .FRAC    (FRAC),
            .RELU_EN (RELU_EN)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .w_we     ((state == ST_LOAD_W) && w_valid && (wf == FW'(f))),
            .w_tap    (wt),
            .w_data   (w_in),
            .acc_clr  (prime),
            .mac_en   (conv_run && (step < FIN_STEP)),
            .fin_en   (conv_fin),
            .first    (q == 2'd0),
            .tap      (tap_idx),
            .pix      (pix_rd),
            .pool_val (pool_bus[f*DATA_W +: DATA_W])
        );
    end

endmodule
